// File: rtl/iir_ctrl.sv
// iir_ctrl: handshake and coefficient controller for an external first-order
// IIR datapath. Samples are accepted in IDLE, the datapath is kicked for one
// cycle (LOAD), the result is collected after LAT cycles (WAIT) and held until
// the consumer takes it (HOLD). Coefficients are written to shadow registers
// and copied to the active set atomically, only while the controller is idle.
// Optional feature: define IIR_CTRL_CNT_EN to add the sample_cnt output.
module iir_ctrl #(
  parameter int           W       = 16,
  parameter int           LAT     = 1,
  parameter logic [W-1:0] B0_INIT = 16'h060A,
  parameter logic [W-1:0] B1_INIT = 16'h060A,
  parameter logic [W-1:0] A1_INIT = 16'h0414
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  input  logic         cfg_commit,
  output logic [W-1:0] iir_x,
  output logic [W-1:0] iir_b0,
  output logic [W-1:0] iir_b1,
  output logic [W-1:0] iir_a1,
  output logic         iir_en,
  input  logic [W-1:0] iir_y,
  output logic         busy,
`ifdef IIR_CTRL_CNT_EN
  output logic [15:0]  sample_cnt,
`endif
  output logic         cfg_pend
);

  // Counter only needs to hold LAT-1.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    out_data_q;
  logic            out_valid_q;
  logic            iir_en_q;

  logic [W-1:0]    b0_sh_q, b1_sh_q, a1_sh_q;
  logic [W-1:0]    b0_sh_d, b1_sh_d, a1_sh_d;
  logic [W-1:0]    b0_act_q, b1_act_q, a1_act_q;
  logic [W-1:0]    b0_act_d, b1_act_d, a1_act_d;
  logic            pend_q, pend_d;
  logic            copy_s;

  // A pending commit blocks new samples so the copy lands between samples.
  assign in_ready  = (state_q == ST_IDLE) && !pend_q;
  assign busy      = (state_q != ST_IDLE);
  assign cfg_pend  = pend_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign iir_x     = x_q;
  assign iir_en    = iir_en_q;
  assign iir_b0    = b0_act_q;
  assign iir_b1    = b1_act_q;
  assign iir_a1    = a1_act_q;

  // Sample FSM with registered datapath strobe and output holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      x_q         <= {W{1'b0}};
      out_data_q  <= {W{1'b0}};
      out_valid_q <= 1'b0;
      iir_en_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            x_q      <= in_data;
            iir_en_q <= 1'b1;      // high for the single LOAD cycle
            state_q  <= ST_LOAD;
          end else begin
            iir_en_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          iir_en_q <= 1'b0;
          cnt_q    <= CW'(LAT - 1);
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == {CW{1'b0}}) begin
            out_data_q  <= iir_y;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          iir_en_q    <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Copy happens in the first idle cycle that sees a pending commit.
  assign copy_s = pend_q && (state_q == ST_IDLE);

  // Next-state for shadow writes, active copy and commit bookkeeping.
  always_comb begin
    b0_sh_d = b0_sh_q;
    b1_sh_d = b1_sh_q;
    a1_sh_d = a1_sh_q;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    b0_sh_d = cfg_wdata;
        2'd1:    b1_sh_d = cfg_wdata;
        2'd2:    a1_sh_d = cfg_wdata;
        default: b0_sh_d = b0_sh_q;   // address 3 has no register
      endcase
    end else begin
      b0_sh_d = b0_sh_q;
    end

    if (copy_s) begin
      b0_act_d = b0_sh_q;
      b1_act_d = b1_sh_q;
      a1_act_d = a1_sh_q;
    end else begin
      b0_act_d = b0_act_q;
      b1_act_d = b1_act_q;
      a1_act_d = a1_act_q;
    end

    // A commit arriving on the copy cycle re-arms so its write is not lost.
    if (cfg_commit) begin
      pend_d = 1'b1;
    end else if (copy_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Coefficient and commit-pending registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0_sh_q  <= B0_INIT;
      b1_sh_q  <= B1_INIT;
      a1_sh_q  <= A1_INIT;
      b0_act_q <= B0_INIT;
      b1_act_q <= B1_INIT;
      a1_act_q <= A1_INIT;
      pend_q   <= 1'b0;
    end else begin
      b0_sh_q  <= b0_sh_d;
      b1_sh_q  <= b1_sh_d;
      a1_sh_q  <= a1_sh_d;
      b0_act_q <= b0_act_d;
      b1_act_q <= b1_act_d;
      a1_act_q <= a1_act_d;
      pend_q   <= pend_d;
    end
  end

`ifdef IIR_CTRL_CNT_EN
  logic [15:0] sample_cnt_q;
  assign sample_cnt = sample_cnt_q;

  // Completed-output counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= 16'h0000;
    end else if (out_valid_q && out_ready) begin
      sample_cnt_q <= sample_cnt_q + 16'h0001;
    end else begin
      sample_cnt_q <= sample_cnt_q;
    end
  end
`endif

endmodule
